// File: rtl/alu_ctrl_mc.sv
// ALU control decode plus a multi-cycle mult/div issue tracker; decode is combinational, MD ops stay busy MUL_LAT/DIV_LAT cycles.
// Backpressure: stall_o holds MD/MFHI/MFLO issue while an op is in flight; ALU_CTRL_DIV_EN enables DIV/DIVU tracking.
module alu_ctrl_mc #(
    parameter int MUL_LAT = 4,
    parameter int DIV_LAT = 32
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       valid_i,
    input  logic [5:0] funct_i,
    input  logic [4:0] ALUOp_i,
    output logic [4:0] ALUCtrl_o,
    output logic       JR_o,
    output logic       SR_o,
    output logic       md_start_o,
    output logic [1:0] md_op_o,
    output logic       busy_o,
    output logic       md_done_o,
    output logic       stall_o
);

    typedef enum logic {IDLE, BUSY} state_t;

    localparam logic [5:0] MUL_CNT = 6'(MUL_LAT - 1);
    localparam logic [5:0] DIV_CNT = 6'(DIV_LAT - 1);

    state_t     r_state, w_state_nxt;
    logic [5:0] r_cnt, w_cnt_nxt;
    logic [1:0] r_md_op, w_md_op_nxt;

    logic w_rtype, w_is_mul, w_is_div, w_is_md, w_is_mf, w_accept;

    always_comb begin
        ALUCtrl_o = ALUOp_i;
        JR_o      = 1'b0;
        SR_o      = 1'b0;
        if (ALUOp_i == 5'd0) begin
            case (funct_i)
                6'h20: ALUCtrl_o = 5'h01;
                6'h21: ALUCtrl_o = 5'h02;
                6'h22: ALUCtrl_o = 5'h03;
                6'h24: ALUCtrl_o = 5'h04;
                6'h25: ALUCtrl_o = 5'h05;
                6'h26: ALUCtrl_o = 5'h06;
                6'h27: ALUCtrl_o = 5'h07;
                6'h28: ALUCtrl_o = 5'h08;
                6'h2A: ALUCtrl_o = 5'h09;
                6'h00: begin ALUCtrl_o = 5'h0A; SR_o = 1'b1; end
                6'h02: begin ALUCtrl_o = 5'h0B; SR_o = 1'b1; end
                6'h03: begin ALUCtrl_o = 5'h0B; SR_o = 1'b1; end
                6'h08: begin ALUCtrl_o = 5'h0C; JR_o = 1'b1; end
                6'h10: ALUCtrl_o = 5'h12;
                6'h12: ALUCtrl_o = 5'h13;
                default: ALUCtrl_o = ALUOp_i;
            endcase
        end
    end

    assign w_rtype  = valid_i && (ALUOp_i == 5'd0);
    assign w_is_mul = (funct_i == 6'h18) || (funct_i == 6'h19);
`ifdef ALU_CTRL_DIV_EN
    assign w_is_div = (funct_i == 6'h1A) || (funct_i == 6'h1B);
`else
    // Divide ops fall through as undecoded; DIV_LAT is kept only for a uniform parameter list.
    logic w_unused_div;
    assign w_is_div     = 1'b0;
    assign w_unused_div = ^DIV_CNT;
`endif
    assign w_is_md  = w_is_mul || w_is_div;
    assign w_is_mf  = (funct_i == 6'h10) || (funct_i == 6'h12);

    assign busy_o     = (r_state == BUSY);
    assign md_done_o  = busy_o && (r_cnt == 6'd0);
    assign md_op_o    = r_md_op;
    // The done cycle is free for a new issue, which gives back-to-back ops with no bubble.
    assign w_accept   = w_rtype && w_is_md && (!busy_o || md_done_o) && !rst_i;
    assign md_start_o = w_accept;
    assign stall_o    = w_rtype && busy_o && !md_done_o && (w_is_md || w_is_mf) && !rst_i;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_md_op_nxt = r_md_op;
        if (w_accept) begin
            w_state_nxt = BUSY;
            w_md_op_nxt = funct_i[1:0];
`ifdef ALU_CTRL_DIV_EN
            w_cnt_nxt   = w_is_mul ? MUL_CNT : DIV_CNT;
`else
            w_cnt_nxt   = MUL_CNT;
`endif
        end else if (r_state == BUSY) begin
            if (r_cnt != 6'd0) begin
                w_cnt_nxt = r_cnt - 6'd1;
            end else begin
                w_state_nxt = IDLE;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= IDLE;
            r_cnt   <= 6'd0;
            r_md_op <= 2'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_md_op <= w_md_op_nxt;
        end
    end

endmodule

// File: tb/tb_alu_ctrl_mc.sv
// Testbench for alu_ctrl_mc: decode vector table, hand-written multi-cycle sequences,
// and randomized traffic against a remaining-cycles reference model.
module tb_alu_ctrl_mc;

    localparam int MUL_LAT = 4;
    localparam int DIV_LAT = 32;
`ifdef ALU_CTRL_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       valid = 1'b0;
    logic [5:0] funct = 6'd0;
    logic [4:0] aluop = 5'd0;
    logic [4:0] ctrl;
    logic       jr, sr, md_start, busy, md_done, stall;
    logic [1:0] md_op;

    always #5 clk = ~clk;

    alu_ctrl_mc #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
        .clk_i(clk), .rst_i(rst), .valid_i(valid), .funct_i(funct), .ALUOp_i(aluop),
        .ALUCtrl_o(ctrl), .JR_o(jr), .SR_o(sr), .md_start_o(md_start), .md_op_o(md_op),
        .busy_o(busy), .md_done_o(md_done), .stall_o(stall)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: cycles of busy left including the current one, and the latched op.
    int m_left = 0;
    int m_op   = 0;

    logic [4:0] s_ctrl;
    logic       s_jr, s_sr, s_start, s_busy, s_done, s_stall;
    logic [1:0] s_op;

    typedef struct {
        logic [4:0] op;
        logic [5:0] f;
        logic [4:0] ctrl;
        logic       jr;
        logic       sr;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void ref_dec(input logic [4:0] op, input logic [5:0] f,
                                    output int c, output int j, output int s);
        int fc[15] = '{'h20, 'h21, 'h22, 'h24, 'h25, 'h26, 'h27, 'h28, 'h2A,
                       'h00, 'h02, 'h03, 'h08, 'h10, 'h12};
        int cc[15] = '{'h01, 'h02, 'h03, 'h04, 'h05, 'h06, 'h07, 'h08, 'h09,
                       'h0A, 'h0B, 'h0B, 'h0C, 'h12, 'h13};
        c = op;
        j = 0;
        s = 0;
        if (op == 0) begin
            for (int i = 0; i < 15; i++) if (f == fc[i]) c = cc[i];
            j = (f == 'h08);
            s = (f == 'h00) || (f == 'h02) || (f == 'h03);
        end
    endfunction

    function automatic bit is_mul(input logic [5:0] f);
        return (f == 'h18) || (f == 'h19);
    endfunction

    function automatic bit is_md(input logic [5:0] f);
        return is_mul(f) || (DIV_EN && ((f == 'h1A) || (f == 'h1B)));
    endfunction

    // One clock cycle: drive, check every output against the model, then advance the model.
    task automatic step(input logic v, input logic [5:0] f, input logic [4:0] op, input logic r);
        int  ec, ej, es;
        bit  rtype, e_busy, e_done, e_acc, e_stall;
        valid = v; funct = f; aluop = op; rst = r;
        ref_dec(op, f, ec, ej, es);
        rtype   = v && (op == 0);
        e_busy  = (m_left > 0);
        e_done  = (m_left == 1);
        e_acc   = rtype && is_md(f) && (!e_busy || e_done) && !r;
        e_stall = rtype && e_busy && !e_done && (is_md(f) || f == 'h10 || f == 'h12) && !r;
        #2;
        s_ctrl = ctrl; s_jr = jr; s_sr = sr; s_start = md_start;
        s_busy = busy; s_done = md_done; s_stall = stall; s_op = md_op;
        chk("alu_ctrl", ctrl, ec);
        chk("jr", jr, ej);
        chk("sr", sr, es);
        chk("md_start", md_start, int'(e_acc));
        chk("busy", busy, int'(e_busy));
        chk("md_done", md_done, int'(e_done));
        chk("stall", stall, int'(e_stall));
        chk("md_op", md_op, m_op);
        @(posedge clk);
        if (r) begin
            m_left = 0;
            m_op   = 0;
        end else if (e_acc) begin
            m_left = is_mul(f) ? MUL_LAT : DIV_LAT;
            m_op   = f % 4;
        end else if (m_left > 0) begin
            m_left--;
        end
        #1;
    endtask

    initial begin
        vec_t       tab[$];
        int         run, stalls, done_at, seen_done, lat, abort_idx;
        logic [5:0] f_md, fr;
        logic [4:0] opr;
        logic [5:0] picks[11] = '{6'h18, 6'h19, 6'h1A, 6'h1B, 6'h10, 6'h12,
                                  6'h20, 6'h08, 6'h00, 6'h2A, 6'h03};

        tab.push_back('{5'h00, 6'h20, 5'h01, 1'b0, 1'b0});
        tab.push_back('{5'h00, 6'h21, 5'h02, 1'b0, 1'b0});
        tab.push_back('{5'h00, 6'h22, 5'h03, 1'b0, 1'b0});
        tab.push_back('{5'h00, 6'h24, 5'h04, 1'b0, 1'b0});
        tab.push_back('{5'h00, 6'h25, 5'h05, 1'b0, 1'b0});
        tab.push_back('{5'h00, 6'h26, 5'h06, 1'b0, 1'b0});
        tab.push_back('{5'h00, 6'h27, 5'h07, 1'b0, 1'b0});
        tab.push_back('{5'h00, 6'h28, 5'h08, 1'b0, 1'b0});
        tab.push_back('{5'h00, 6'h2A, 5'h09, 1'b0, 1'b0});
        tab.push_back('{5'h00, 6'h00, 5'h0A, 1'b0, 1'b1});
        tab.push_back('{5'h00, 6'h02, 5'h0B, 1'b0, 1'b1});
        tab.push_back('{5'h00, 6'h03, 5'h0B, 1'b0, 1'b1});
        tab.push_back('{5'h00, 6'h08, 5'h0C, 1'b1, 1'b0});
        tab.push_back('{5'h00, 6'h10, 5'h12, 1'b0, 1'b0});
        tab.push_back('{5'h00, 6'h12, 5'h13, 1'b0, 1'b0});
        tab.push_back('{5'h00, 6'h3F, 5'h00, 1'b0, 1'b0});
        tab.push_back('{5'h0D, 6'h08, 5'h0D, 1'b0, 1'b0});
        tab.push_back('{5'h1F, 6'h00, 5'h1F, 1'b0, 1'b0});
        tab.push_back('{5'h03, 6'h20, 5'h03, 1'b0, 1'b0});
        tab.push_back('{5'h00, 6'h1A, 5'h00, 1'b0, 1'b0});

        // Reset held with an MD op presented: no start, idle afterwards.
        step(1, 6'h18, 5'd0, 1);
        step(1, 6'h18, 5'd0, 1);
        chk("rst_start", s_start, 0);
        step(0, 6'h00, 5'd0, 0);
        chk("rst_busy", s_busy, 0);
        chk("rst_md_op", s_op, 0);

        // SLT decode from idle.
        step(1, 6'h2A, 5'd0, 0);
        chk("slt_ctrl", s_ctrl, 'h09);

        foreach (tab[i]) begin
            step(1, tab[i].f, tab[i].op, 0);
            chk("tab_ctrl", s_ctrl, tab[i].ctrl);
            chk("tab_jr", s_jr, tab[i].jr);
            chk("tab_sr", s_sr, tab[i].sr);
        end
        for (int i = 0; i < DIV_LAT + 2; i++) step(0, 6'h00, 5'd0, 0);

        // Single MULT: busy exactly MUL_LAT cycles, done in the last.
        step(1, 6'h18, 5'd0, 0);
        chk("mult_start", s_start, 1);
        run = 0; done_at = -1;
        for (int i = 0; i < MUL_LAT + 2; i++) begin
            step(0, 6'h00, 5'd0, 0);
            run += int'(s_busy);
            if (s_done) done_at = i;
        end
        chk("mult_busy_cycles", run, MUL_LAT);
        chk("mult_done_at", done_at, MUL_LAT - 1);
        chk("mult_md_op", s_op, 0);

        // MFLO held behind an in-flight op stalls until the done cycle.
        f_md = DIV_EN ? 6'h1B : 6'h19;
        lat  = DIV_EN ? DIV_LAT : MUL_LAT;
        step(1, f_md, 5'd0, 0);
        stalls = 0;
        for (int i = 0; i < lat; i++) begin
            step(1, 6'h12, 5'd0, 0);
            stalls += int'(s_stall);
            chk("mflo_ctrl", s_ctrl, 'h13);
            if (i == lat - 1) chk("mflo_done_nostall", s_stall, 0);
        end
        chk("mflo_stall_cycles", stalls, lat - 1);
        chk("md_op_held", s_op, f_md % 4);
        step(1, 6'h12, 5'd0, 0);
        chk("mflo_idle_nostall", s_stall, 0);

        // MULTU, ADD during busy, then MULT in the done cycle: busy continuous 2*MUL_LAT.
        step(1, 6'h19, 5'd0, 0);
        run = 0;
        step(1, 6'h20, 5'd0, 0);
        run += int'(s_busy);
        chk("add_busy_ctrl", s_ctrl, 'h01);
        chk("add_busy_stall", s_stall, 0);
        for (int i = 0; i < MUL_LAT - 2; i++) begin
            step(0, 6'h00, 5'd0, 0);
            run += int'(s_busy);
        end
        step(1, 6'h18, 5'd0, 0);
        run += int'(s_busy);
        chk("b2b_start", s_start, 1);
        chk("b2b_in_done", s_done, 1);
        for (int i = 0; i < MUL_LAT + 2; i++) begin
            step(0, 6'h00, 5'd0, 0);
            run += int'(s_busy);
        end
        chk("b2b_busy_cycles", run, 2 * MUL_LAT);

        // Reset mid-operation aborts with no done pulse.
        f_md = DIV_EN ? 6'h1A : 6'h18;
        abort_idx = DIV_EN ? DIV_LAT - 11 : 1;
        step(1, f_md, 5'd0, 0);
        seen_done = 0;
        for (int i = 0; i < abort_idx; i++) begin
            step(0, 6'h00, 5'd0, 0);
            seen_done += int'(s_done);
        end
        step(0, 6'h00, 5'd0, 1);
        chk("abort_busy_during_rst", s_busy, 1);
        for (int i = 0; i < 4; i++) begin
            step(0, 6'h00, 5'd0, 0);
            seen_done += int'(s_done);
            chk("abort_busy", s_busy, 0);
            chk("abort_md_op", s_op, 0);
        end
        chk("abort_no_done", seen_done, 0);

        // DIV in the default build is just an undecoded funct.
        step(1, 6'h1A, 5'd0, 0);
        if (!DIV_EN) begin
            chk("nodiv_ctrl", s_ctrl, 0);
            chk("nodiv_start", s_start, 0);
        end
        for (int i = 0; i < DIV_LAT + 2; i++) step(0, 6'h00, 5'd0, 0);

        for (int n = 0; n < 3000; n++) begin
            fr  = ($urandom_range(0, 4) == 0) ? 6'($urandom) : picks[$urandom_range(0, 10)];
            opr = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'd0;
            step(($urandom_range(0, 4) != 0), fr, opr, ($urandom_range(0, 49) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
